// File: rtl/apb_input_monitor.sv
// apb_input_monitor: APB-mapped monitor for asynchronous 8-bit input channels.
// Each input bit is synchronised. Rising and falling edges of the synchronised
// value set sticky W1C flags. Per-bit enables turn those flags into a per-channel
// pending bit and a registered level interrupt. A saturating per-channel counter
// counts cycles with an enabled edge. A global trigger snapshots every channel.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   psel, penable     APB select / access phase
//   paddr[7:0]        [7:4] channel (0xF = global), [3:0] register offset
//   pwrite, pwdata    APB write strobe / data
//   prdata, pready    APB read data (combinational) / ready (no wait states)
//   in_bus            asynchronous inputs, channel c = in_bus[8c+7:8c]
//   irq               registered OR of all channel pending bits
module apb_input_monitor #(
   parameter int unsigned CHANNELS    = 2,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  psel,
   input  logic [7:0]            paddr,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [7:0]            pwdata,
   output logic [7:0]            prdata,
   output logic                  pready,
   input  logic [8*CHANNELS-1:0] in_bus,
   output logic                  irq
);

   localparam logic [3:0] GlobalCh = 4'hF;

   logic [SYNC_STAGES-1:0][8*CHANNELS-1:0] sync_q;
   logic [CHANNELS-1:0][7:0] value, prev_q, rise_evt, fall_evt;
   logic [CHANNELS-1:0][7:0] rise_q, rise_d, fall_q, fall_d;
   logic [CHANNELS-1:0][7:0] rise_en_q, rise_en_d, fall_en_q, fall_en_d;
   logic [CHANNELS-1:0][7:0] snap_q, snap_d, count_q, count_d;
   logic [CHANNELS-1:0]      pending, cnt_evt;
   logic                     irq_q;

   logic       access, wr, rd, snap_trig;
   logic [3:0] chan, off;
   logic [7:0] rdata;

   assign access = psel & penable;
   assign wr     = access & pwrite;
   assign rd     = access & ~pwrite;
   assign chan   = paddr[7:4];
   assign off    = paddr[3:0];

   // Last synchroniser stage is the architectural VALUE; prev_q holds last cycle's.
   assign value    = sync_q[SYNC_STAGES-1];
   assign rise_evt = value & ~prev_q;
   assign fall_evt = ~value & prev_q;

   assign snap_trig = wr && (chan == GlobalCh) && (off == 4'd1) && pwdata[0];

   always_comb begin
      rise_d    = rise_q;
      fall_d    = fall_q;
      rise_en_d = rise_en_q;
      fall_en_d = fall_en_q;
      snap_d    = snap_q;
      count_d   = count_q;
      pending   = '0;
      cnt_evt   = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         // W1C: a new edge in the same cycle wins over the clear.
         rise_d[c] = (rise_q[c] & ~((wr && chan == 4'(c) && off == 4'd1) ? pwdata : 8'h00))
                     | rise_evt[c];
         fall_d[c] = (fall_q[c] & ~((wr && chan == 4'(c) && off == 4'd2) ? pwdata : 8'h00))
                     | fall_evt[c];
         if (wr && chan == 4'(c) && off == 4'd3) rise_en_d[c] = pwdata;
         if (wr && chan == 4'(c) && off == 4'd4) fall_en_d[c] = pwdata;

         cnt_evt[c] = |((rise_evt[c] & rise_en_q[c]) | (fall_evt[c] & fall_en_q[c]));
         // Clear and increment together leave the count at 1.
         if (wr && chan == 4'(c) && off == 4'd6) begin
            count_d[c] = {7'd0, cnt_evt[c]};
         end else if (cnt_evt[c] && count_q[c] != 8'hFF) begin
            count_d[c] = count_q[c] + 8'd1;
         end

         pending[c] = |((rise_q[c] & rise_en_q[c]) | (fall_q[c] & fall_en_q[c]));
      end
      if (snap_trig) snap_d = value;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q    <= '0;
         prev_q    <= '0;
         rise_q    <= '0;
         fall_q    <= '0;
         rise_en_q <= '0;
         fall_en_q <= '0;
         snap_q    <= '0;
         count_q   <= '0;
         irq_q     <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], in_bus};
         prev_q    <= value;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         rise_en_q <= rise_en_d;
         fall_en_q <= fall_en_d;
         snap_q    <= snap_d;
         count_q   <= count_d;
         irq_q     <= |pending;
      end
   end

   always_comb begin
      rdata = 8'h00;
      if (chan == GlobalCh) begin
         case (off)
            4'd0:    rdata = 8'(CHANNELS);
            4'd2:    rdata[CHANNELS-1:0] = pending;
            default: rdata = 8'h00;
         endcase
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (chan == 4'(c)) begin
               case (off)
                  4'd0:    rdata = value[c];
                  4'd1:    rdata = rise_q[c];
                  4'd2:    rdata = fall_q[c];
                  4'd3:    rdata = rise_en_q[c];
                  4'd4:    rdata = fall_en_q[c];
                  4'd5:    rdata = snap_q[c];
                  4'd6:    rdata = count_q[c];
                  default: rdata = 8'h00;
               endcase
            end
         end
      end
   end

   assign pready = access;
   assign prdata = (rd && rst_n) ? rdata : 8'h00;
   assign irq    = irq_q;

endmodule

// File: tb/tb_apb_input_monitor.sv
// Directed bench for apb_input_monitor (CHANNELS=2, SYNC_STAGES=2): a register
// vector table plus timed sequences for latency, W1C races, saturation,
// snapshot and reset behaviour.
module tb_apb_input_monitor;

   logic        clk;
   logic        rst_n;
   logic        psel;
   logic [7:0]  paddr;
   logic        penable;
   logic        pwrite;
   logic [7:0]  pwdata;
   logic [7:0]  prdata;
   logic        pready;
   logic [15:0] in_bus;
   logic        irq;

   int tests;
   int fails;

   apb_input_monitor #(
      .CHANNELS    (2),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .psel    (psel),
      .paddr   (paddr),
      .penable (penable),
      .pwrite  (pwrite),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .pready  (pready),
      .in_bus  (in_bus),
      .irq     (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       is_wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
      end
   endtask

   task automatic idle();
      psel    = 1'b0;
      penable = 1'b0;
      pwrite  = 1'b0;
   endtask

   task automatic apb_write(input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      idle();
   endtask

   task automatic rd_check(input string name, input logic [7:0] addr, input logic [7:0] exp);
      logic [7:0] d;
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
      @(negedge clk);
      penable = 1'b1;
      #1 d = prdata;
      check(name, d, exp);
      check({name, "_pready"}, {7'd0, pready}, 8'h01);
      @(negedge clk);
      idle();
   endtask

   // Held-open read: sample a register without spending setup cycles.
   task automatic peek(input logic [7:0] addr, output logic [7:0] data);
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = addr;
      #1 data = prdata;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      tests = 0;
      fails = 0;
      rst_n = 1'b0;
      in_bus = '0;
      paddr = '0;
      pwdata = '0;
      idle();

      vecs[0]  = '{1'b0, 8'hF0, 8'h00, 8'h02};
      vecs[1]  = '{1'b0, 8'h00, 8'h00, 8'h00};
      vecs[2]  = '{1'b0, 8'hF2, 8'h00, 8'h00};
      vecs[3]  = '{1'b1, 8'h14, 8'h3C, 8'h3C};
      vecs[4]  = '{1'b1, 8'h37, 8'hFF, 8'h00};
      vecs[5]  = '{1'b1, 8'h07, 8'hFF, 8'h00};
      vecs[6]  = '{1'b0, 8'hF3, 8'h00, 8'h00};
      vecs[7]  = '{1'b1, 8'hF1, 8'h00, 8'h00};
      vecs[8]  = '{1'b1, 8'h05, 8'hFF, 8'h00};
      vecs[9]  = '{1'b1, 8'h00, 8'hFF, 8'h00};
      vecs[10] = '{1'b1, 8'h14, 8'h00, 8'h00};
      vecs[11] = '{1'b1, 8'h03, 8'hA5, 8'hA5};
      vecs[12] = '{1'b1, 8'h03, 8'h00, 8'h00};
      vecs[13] = '{1'b0, 8'h27, 8'h00, 8'h00};
      vecs[14] = '{1'b1, 8'h27, 8'hFF, 8'h00};
      vecs[15] = '{1'b1, 8'h16, 8'hFF, 8'h00};

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_irq", {7'd0, irq}, 8'h00);
      check("rst_pready", {7'd0, pready}, 8'h00);
      check("rst_prdata", prdata, 8'h00);
      rst_n = 1'b1;

      // Register map vectors
      foreach (vecs[i]) begin
         if (vecs[i].is_wr) apb_write(vecs[i].addr, vecs[i].data);
         rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      end

      // Sync latency and flag latency, masks all zero
      @(negedge clk);
      in_bus[7:0] = 8'h5A;
      @(negedge clk);
      peek(8'h00, d); check("lat_val_t", d, 8'h00);
      @(negedge clk);
      peek(8'h00, d); check("lat_val_t1", d, 8'h5A);
      peek(8'h01, d); check("lat_rise_t1", d, 8'h00);
      @(negedge clk);
      peek(8'h01, d); check("lat_rise_t2", d, 8'h5A);
      check("lat_irq", {7'd0, irq}, 8'h00);
      @(negedge clk);
      idle();
      apb_write(8'h01, 8'h0F);
      rd_check("w1c_partial", 8'h01, 8'h50);
      in_bus[7:0] = 8'h00;
      repeat (4) @(negedge clk);
      rd_check("fall_flags", 8'h02, 8'h5A);
      apb_write(8'h01, 8'hFF);
      apb_write(8'h02, 8'hFF);
      rd_check("rise_clr", 8'h01, 8'h00);
      rd_check("fall_clr", 8'h02, 8'h00);

      // Enabled rise -> count, pending, registered irq, W1C drops irq
      apb_write(8'h03, 8'h0F);
      @(negedge clk);
      in_bus[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      peek(8'h01, d); check("en_rise", d, 8'h01);
      peek(8'h06, d); check("en_count", d, 8'h01);
      peek(8'hF2, d); check("en_irqstat", d, 8'h01);
      check("en_irq_early", {7'd0, irq}, 8'h00);
      @(negedge clk);
      check("en_irq", {7'd0, irq}, 8'h01);
      idle();
      apb_write(8'h01, 8'h01);
      check("irq_hold", {7'd0, irq}, 8'h01);
      @(negedge clk);
      check("irq_clear", {7'd0, irq}, 8'h00);

      // W1C racing a new rise on the same bit
      in_bus[0] = 1'b0;
      repeat (4) @(negedge clk);
      in_bus[0] = 1'b1;
      repeat (4) @(negedge clk);
      in_bus[0] = 1'b0;
      repeat (4) @(negedge clk);
      in_bus[0] = 1'b1;
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h01; pwdata = 8'h01;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      idle();
      rd_check("race_rise", 8'h01, 8'h01);
      rd_check("race_count", 8'h06, 8'h03);
      apb_write(8'h03, 8'h00);
      apb_write(8'h01, 8'hFF);
      apb_write(8'h02, 8'hFF);

      // Saturation on ch1, then clear racing an edge
      apb_write(8'h13, 8'hFF);
      apb_write(8'h14, 8'hFF);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         in_bus[8] = ~in_bus[8];
      end
      repeat (4) @(negedge clk);
      rd_check("sat_count", 8'h16, 8'hFF);
      rd_check("sat_irqstat", 8'hF2, 8'h02);
      check("sat_irq", {7'd0, irq}, 8'h01);
      @(negedge clk);
      in_bus[8] = ~in_bus[8];
      @(negedge clk);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h16; pwdata = 8'h00;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      idle();
      rd_check("clr_race_count", 8'h16, 8'h01);

      // Snapshot; ch0 VALUE changes on the trigger edge
      in_bus = 16'hC433;
      repeat (4) @(negedge clk);
      in_bus[7:0] = 8'h77;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'hF1; pwdata = 8'h01;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      idle();
      rd_check("snap_ch0", 8'h05, 8'h33);
      rd_check("snap_ch1", 8'h15, 8'hC4);
      rd_check("snap_val0", 8'h00, 8'h77);
      rd_check("id", 8'hF0, 8'h02);
      rd_check("unmapped27", 8'h27, 8'h00);

      // Reset pulse with state populated and an access in flight
      apb_write(8'h03, 8'h11);
      in_bus = '0;
      repeat (4) @(negedge clk);
      check("pre_rst_irq", {7'd0, irq}, 8'h01);
      rst_n = 1'b0;
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 8'h15;
      #1;
      check("rst_rd_prdata", prdata, 8'h00);
      check("rst_rd_pready", {7'd0, pready}, 8'h01);
      @(negedge clk);
      pwrite = 1'b1; paddr = 8'h03; pwdata = 8'hFF;
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      repeat (4) @(negedge clk);
      for (int c = 0; c < 2; c++) begin
         for (int o = 0; o < 7; o++) begin
            rd_check($sformatf("post_rst_c%0d_r%0d", c, o), 8'(c * 16 + o), 8'h00);
         end
      end
      rd_check("post_rst_irqstat", 8'hF2, 8'h00);
      check("post_rst_irq", {7'd0, irq}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
